// File: rtl/serial_addsub_pkg.sv
// Shared state encoding and mode constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_addsub_cell.sv
// One-bit full adder/subtractor: sum/difference plus carry-out/borrow-out.
module full_addsub_cell
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c_in,
    input  logic mode,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (mode == MODE_SUB) ? ((~x & y) | (c_in & ~(x ^ y)))
                                      : ((x & y) | (c_in & (x ^ y)));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVERFLOW_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing bit cnt of the latched operands
// DONE  | one-cycle done pulse; start here is accepted as in IDLE
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             mode_q;
    logic             s;
    logic             c_out;

    full_addsub_cell u_cell (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .c_in  (carry),
        .mode  (mode_q),
        .s     (s),
        .c_out (c_out)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {s, {(WIDTH-1){1'b0}}} | (res_sr >> 1);

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    // On the last bit a_sr[0]/b_sr[0] are the latched operand MSBs.
    logic ovf_next;
    assign ovf_next = ((mode_q == MODE_SUB) ? (a_sr[0] != b_sr[0]) : (a_sr[0] == b_sr[0]))
                      && (s != a_sr[0]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            mode_q       <= MODE_ADD;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            carry_borrow <= 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
            ovf          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        mode_q <= mode;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= c_out;
                    if (cnt == LAST) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result       <= res_next;
                        carry_borrow <= c_out;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
                        ovf          <= ovf_next;
`endif
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub against an arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_borrow;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] hold_res = '0;
    logic         hold_cb  = 1'b0;
    logic         hold_ovf = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry_borrow (carry_borrow)
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1 of cycle 0; returns at posedge+1 of the done cycle.
    // hold keeps start high through the run so the caller can chain another op.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                         input bit noise, input bit hold);
        logic [W:0] full;
        int         sr;
        logic       e_ovf;
        full  = tm ? ({1'b0, ta} - {1'b0, tb}) : ({1'b0, ta} + {1'b0, tb});
        sr    = tm ? (int'($signed(ta)) - int'($signed(tb))) : (int'($signed(ta)) + int'($signed(tb)));
        e_ovf = (sr > 127) || (sr < -128);
        start = 1'b1;
        a     = ta;
        b     = tb;
        mode  = tm;
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge clk);
            #1;
            if (c <= W) begin
                start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
                if (noise) begin
                    a    = W'($urandom);
                    b    = W'($urandom);
                    mode = 1'($urandom_range(0, 1));
                end
                check("busy_run", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                check("result_hold", 32'(result), 32'(hold_res));
                check("cb_hold", 32'(carry_borrow), 32'(hold_cb));
            end else begin
                start = hold;
                check("done_pulse", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("result", 32'(result), 32'(full[W-1:0]));
                check("carry_borrow", 32'(carry_borrow), 32'(full[W]));
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
                check("ovf", 32'(ovf), 32'(e_ovf));
`endif
                hold_res = full[W-1:0];
                hold_cb  = full[W];
                hold_ovf = e_ovf;
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_result", 32'(result), 32'(hold_res));
        end
    endtask

    initial begin
        bit saw_done;
        bit chain;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cb", 32'(carry_borrow), 32'd0);
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(8'h3C, 8'h15, 1'b0, 1'b0, 1'b0);
        idle_check(1);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_check(2);
        do_op(8'h15, 8'h3C, 1'b1, 1'b0, 1'b0);
        do_op(8'h50, 8'h50, 1'b1, 1'b0, 1'b0);
        idle_check(1);
        do_op(8'h3C, 8'h15, 1'b0, 1'b0, 1'b1);
        do_op(8'h15, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle_check(1);
        do_op(8'h3C, 8'h15, 1'b0, 1'b1, 1'b0);
        idle_check(1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        do_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        idle_check(1);

        // Abort while bit 4 is being processed.
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h15;
        mode  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cb", 32'(carry_borrow), 32'd0);
        hold_res = '0;
        hold_cb  = 1'b0;
        hold_ovf = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        do_op(8'h3C, 8'h15, 1'b0, 1'b0, 1'b0);
        idle_check(1);

        for (int i = 0; i < 40; i++) begin
            chain = (i < 39) && ($urandom_range(0, 3) == 0);
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), chain);
            if (!chain) idle_check($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, multi-cycle adder/subtractor.
- Chains the one-bit sum/difference and carry/borrow logic across cycles, LSB first, over a WIDTH-bit operand pair.
- mode 0 = add (a + b); mode 1 = subtract (a - b). Same mode encoding as the existing half adder/subtractor cell.
- Sits in the arithmetic datapath, where area matters more than latency; pairs with a start/done controller.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- start, input, 1, request; sampled only when not busy
- mode, input, 1, 0 = add, 1 = subtract; latched with operands
- a, input, WIDTH, first operand (minuend when subtracting)
- b, input, WIDTH, second operand (subtrahend)
- busy, output, 1, high while bits are being processed
- done, output, 1, one-cycle pulse; result and carry_borrow valid
- result, output, WIDTH, sum or difference modulo 2^WIDTH
- carry_borrow, output, 1, final carry-out (add) or final borrow-out (subtract)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. Reset wins over every other input in the same cycle.
- Reset values: state IDLE; busy 0; done 0; result 0; carry_borrow 0. Internal shift registers, bit counter and carry are all cleared.
- States:
  - IDLE: start=1 latches a, b and mode, clears internal carry and counter, and moves to RUN.
  - RUN: one bit per cycle, bit i = counter value. After bit WIDTH-1, move to DONE.
  - DONE: done=1 for exactly one cycle, then move to IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE (latch, go to RUN), giving back-to-back operation.
- Per-bit logic, with x = a_i, y = b_i, c = stored carry/borrow:
  - s = x ^ y ^ c
  - add: c' = (x & y) | (c & (x ^ y))
  - sub: c' = (~x & y) | (c & ~(x ^ y))
- s shifts into the MSB of an internal result shift register, which shifts right each cycle.
- Latency: start is driven in cycle 0. busy=1 in cycles 1..WIDTH. done=1 in cycle WIDTH+1.
- On entry to DONE, result and carry_borrow are loaded from the shift register and the final c'. They then hold until the next completion or reset; a new start does not clear them.
- start while busy is ignored. a, b and mode changes during RUN have no effect.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs return to reset values.
- Wrap-around: the result is modulo 2^WIDTH. Overflow is reported only via carry_borrow (unsigned) or the optional ovf output.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow, loaded at DONE alongside result, reset to 0.
  - add: ovf = (a_msb == b_msb) && (result_msb != a_msb).
  - sub: ovf = (a_msb != b_msb) && (result_msb != a_msb).
  - Operand MSBs are taken from the latched copies.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package serial_addsub_pkg contains:
  - state enum: IDLE, RUN, DONE
  - MODE_ADD = 1'b0, MODE_SUB = 1'b1
- One natural sub-module, full_addsub_cell: purely combinational.
  - Inputs: x, y, c_in, mode.
  - Outputs: s, c_out.
  - Implements the per-bit equations above; instantiated once in serial_addsub.

Test Plan (WIDTH=8):
- Add: a=0x3C, b=0x15, mode=0, start 1 cycle -> busy in cycles 1..8; done in cycle 9; result=0x51; carry_borrow=0.
- Add wrap: a=0xFF, b=0x01, mode=0 -> result=0x00, carry_borrow=1. With SERIAL_ADDSUB_OVERFLOW_EN, ovf=0.
- Subtract: a=0x15, b=0x3C, mode=1 -> result=0xD9, borrow=1. Then a=0x50, b=0x50 -> result=0x00, borrow=0.
- Protocol:
  - Start held high across two operations: the second is accepted in the DONE cycle and its done arrives 9 cycles later.
  - Start pulses and operand changes during RUN are ignored; the first result is unchanged.
- Reset: assert rst at bit 4 of a=0x3C+0x15 -> next cycle busy=0, result=0x00, carry_borrow=0. No done pulse; a following start completes normally.
- SERIAL_ADDSUB_OVERFLOW_EN:
  - 0x7F + 0x01 -> result=0x80, ovf=1.
  - 0x80 - 0x01 (mode=1) -> result=0x7F, ovf=1.
  - 0x10 - 0x01 -> result=0x0F, ovf=0.
